// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal range of the operand width parameter.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell: the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of a single bit position.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder. Operands are captured on an input handshake,
// streamed LSB-first through one full adder cell (one bit per clock, carry
// kept in a flop) and the WIDTH-bit sum plus carry-out are offered on an
// output handshake. Accept and output never overlap.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH must lie in 2..64");
  end

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting, carry and bit counter.
  // NOTE: the datapath registers are reset as well, so a reset mid-operation
  // leaves no stale partial sum that could ever be presented later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result is only driven while it is being offered; zero otherwise.
  always_comb begin
    sum  = out_valid ? sum_sh : '0;
    cout = out_valid ? carry  : 1'b0;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios on an 8-bit
// instance, then randomized traffic on 8-bit and 32-bit instances checked
// against plain integer addition.
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, ci8 = 1'b0, co8, busy8;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, ci32 = 1'b0, co32, busy32;
  logic [31:0] a32 = '0, b32 = '0, s32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(busy8)
  );

  serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(ci32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .busy(busy32)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, one bit wider than the operands.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
    return 33'(x) + 33'(y) + 33'(c);
  endfunction

  // Present one operation from a falling edge; it is accepted on the next
  // rising edge (block must be idle). Operands are scrambled afterwards.
  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic c);
    a8 = x; b8 = y; ci8 = c; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
  endtask

  // Count falling edges until out_valid, noting whether in_ready was ever high.
  task automatic wait_done8(output int cyc, output bit ir_hi);
    cyc = 0; ir_hi = 1'b0;
    while (ov8 !== 1'b1 && cyc < 64) begin
      ir_hi = ir_hi | (ir8 === 1'b1);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
    int cyc; bit ir_hi;
    or8 = 1'b1;
    send8(x, y, c);
    wait_done8(cyc, ir_hi);
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_inready_low"}, ir_hi, 0);
    check({tag, "_result"}, {co8, s8}, ref8(x, y, c));
    @(negedge clk);
    check({tag, "_released"}, {ov8, ir8}, 2'b01);
  endtask

  initial begin
    int          cyc;
    bit          ir_hi;
    int          sent;
    int          recv;
    bit          acc_pend;
    logic [8:0]  q8[$];
    logic [32:0] q32[$];
    localparam int N8 = 1500, LIM8 = 40000, N32 = 700, LIM32 = 45000;

    // Reset values.
    #1;
    check("rst_inready", ir8, 1);
    check("rst_outvalid", ov8, 0);
    check("rst_busy", busy8, 0);
    check("rst_result", {co8, s8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operations and full carry propagation.
    run8("op_5a_3c", 8'h5A, 8'h3C, 1'b0);
    run8("op_ff_01", 8'hFF, 8'h01, 1'b0);
    run8("op_ff_ff_c", 8'hFF, 8'hFF, 1'b1);

    // Backpressure: result held, new request ignored, then both handshakes
    // high in DONE -> only the output completes, accept comes one edge later.
    or8 = 1'b0;
    send8(8'hC3, 8'h4D, 1'b1);
    wait_done8(cyc, ir_hi);
    check("bp_latency", cyc, 8);
    a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_outvalid", ov8, 1);
      check("bp_hold", {co8, s8}, ref8(8'hC3, 8'h4D, 1'b1));
      check("bp_inready", ir8, 0);
    end
    or8 = 1'b1;
    @(negedge clk);
    check("bp_out_only", {ov8, ir8, busy8}, 3'b010);
    @(negedge clk);
    check("b2b_accept", {ir8, busy8}, 2'b01);
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    wait_done8(cyc, ir_hi);
    check("b2b_latency", cyc, 8);
    check("b2b_result", {co8, s8}, ref8(8'h11, 8'h22, 1'b0));
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    send8(8'h5A, 8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {ir8, ov8, busy8, co8, s8}, {1'b1, 1'b0, 1'b0, 9'h000});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_output", {ov8, busy8}, 2'b00);
    run8("after_rst", 8'h01, 8'h02, 1'b0);

    // Random traffic, 8-bit.
    sent = 0; recv = 0; acc_pend = 1'b0; cyc = 0;
    while (recv < N8 && cyc < LIM8) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) begin iv8 = 1'b0; acc_pend = 1'b0; end
      if (!iv8 && sent < N8 && $urandom_range(0, 2) != 0) begin
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); iv8 = 1'b1;
      end
      or8 = ($urandom_range(0, 3) != 0);
      if (iv8 && ir8) begin q8.push_back(ref8(a8, b8, ci8)); sent++; acc_pend = 1'b1; end
      if (ov8 && or8) begin
        check("r8_expected_pending", q8.size() != 0, 1);
        if (q8.size() != 0) check("r8_result", {co8, s8}, q8.pop_front());
        recv++;
      end
    end
    iv8 = 1'b0;
    check("r8_count", recv, N8);
    check("r8_leftover", q8.size(), 0);

    // Random traffic, 32-bit.
    sent = 0; recv = 0; acc_pend = 1'b0; cyc = 0;
    while (recv < N32 && cyc < LIM32) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) begin iv32 = 1'b0; acc_pend = 1'b0; end
      if (!iv32 && sent < N32 && $urandom_range(0, 2) != 0) begin
        a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); iv32 = 1'b1;
      end
      or32 = ($urandom_range(0, 3) != 0);
      if (iv32 && ir32) begin q32.push_back(ref32(a32, b32, ci32)); sent++; acc_pend = 1'b1; end
      if (ov32 && or32) begin
        check("r32_expected_pending", q32.size() != 0, 1);
        if (q32.size() != 0) check("r32_result", {co32, s32}, q32.pop_front());
        recv++;
      end
    end
    iv32 = 1'b0;
    check("r32_count", recv, N32);
    check("r32_leftover", q32.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check("r32_idle", {busy32, ir32}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
